// File: rtl/cp0_if.sv
// CP0 access bus: request channel from the pipeline, response channel back to it.
interface cp0_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [4:0]        req_rd;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_illegal;

  modport master (
    output req_valid, req_write, req_rd, req_sel, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_write, req_rd, req_sel, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/cp0_regfile_ctrl.sv
// CP0 register file with (rd,sel) decode, mfc0/mtc0 valid/ready access with a
// one-entry response buffer, and the Count/Compare timer interrupt.
module cp0_regfile_ctrl #(
  parameter int                        DATA_W     = 32,
  parameter int                        SEL_W      = 3,
  parameter logic [32*(2**SEL_W)-1:0]  IMPL_MASK  = '1,
  parameter int                        COUNT_DIV  = 2,
  parameter logic [DATA_W-1:0]         STATUS_RST = DATA_W'(32'h0040_0004)
) (
  input  logic              clk,
  input  logic              rst_n,
  cp0_if.slave              bus,
  output logic              timer_irq,
  output logic [DATA_W-1:0] count_out
);

  localparam int NUM_SEL  = 2**SEL_W;
  localparam int IDX_W    = 5 + SEL_W;
  localparam int NUM_IDX  = 32 * NUM_SEL;
  localparam int PRE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int CAUSE_TI = 30;

  localparam logic [IDX_W-1:0] COUNT_IDX   = IDX_W'(9  * NUM_SEL);
  localparam logic [IDX_W-1:0] COMPARE_IDX = IDX_W'(11 * NUM_SEL);
  localparam logic [IDX_W-1:0] STATUS_IDX  = IDX_W'(12 * NUM_SEL);
  localparam logic [IDX_W-1:0] CAUSE_IDX   = IDX_W'(13 * NUM_SEL);

  logic [DATA_W-1:0] regs [NUM_IDX];
  logic [DATA_W-1:0] count_q;
  logic [PRE_W-1:0]  presc;
  logic              irq_q;

  logic              rsp_vld_p1;
  logic              rsp_ill_p1;
  logic [DATA_W-1:0] rsp_rdata_p1;

  logic [IDX_W-1:0]  idx_p0;
  logic              legal_p0;
  logic              accept_p0;
  logic              wr_en_p0;
  logic              cnt_wr_p0;
  logic              cmp_wr_p0;
  logic              tick;
  logic [DATA_W-1:0] count_nxt;
  logic [DATA_W-1:0] rd_val_p0;
  logic [DATA_W-1:0] wr_val_p0;

  // ---- p0: decode and accept the request ----
  assign idx_p0        = {bus.req_rd, bus.req_sel};
  assign legal_p0      = IMPL_MASK[idx_p0];
  assign bus.req_ready = !rsp_vld_p1 || bus.rsp_ready;
  assign accept_p0     = bus.req_valid && bus.req_ready;
  assign wr_en_p0      = accept_p0 && bus.req_write && legal_p0;
  assign cnt_wr_p0     = wr_en_p0 && (idx_p0 == COUNT_IDX);
  assign cmp_wr_p0     = wr_en_p0 && (idx_p0 == COMPARE_IDX);
  assign tick          = (presc == PRE_W'(COUNT_DIV - 1));

  always_comb begin
    count_nxt = count_q;
    if (cnt_wr_p0)
      count_nxt = bus.req_wdata;
    else if (tick)
      count_nxt = count_q + DATA_W'(1);
  end

  // Count lives outside the array; Cause bit 30 is the live interrupt, never stored.
  always_comb begin
    rd_val_p0 = regs[idx_p0];
    if (idx_p0 == COUNT_IDX)
      rd_val_p0 = count_q;
    if (idx_p0 == CAUSE_IDX)
      rd_val_p0[CAUSE_TI] = irq_q;
  end

  always_comb begin
    wr_val_p0 = bus.req_wdata;
    if (idx_p0 == CAUSE_IDX)
      wr_val_p0[CAUSE_TI] = 1'b0;
  end

  // ---- p1: register state and buffered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IDX; i++)
        regs[i] <= (i == int'(STATUS_IDX)) ? STATUS_RST : '0;
      count_q      <= '0;
      presc        <= '0;
      irq_q        <= 1'b0;
      rsp_vld_p1   <= 1'b0;
      rsp_ill_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
    end else begin
      if (wr_en_p0)
        regs[idx_p0] <= wr_val_p0;

      count_q <= count_nxt;
      presc   <= (cnt_wr_p0 || tick) ? '0 : presc + PRE_W'(1);

      if (cmp_wr_p0)
        irq_q <= 1'b0;
      else if (count_nxt == regs[COMPARE_IDX])
        irq_q <= 1'b1;

      if (accept_p0) begin
        rsp_vld_p1   <= 1'b1;
        rsp_ill_p1   <= !legal_p0;
        rsp_rdata_p1 <= (!bus.req_write && legal_p0) ? rd_val_p0 : '0;
      end else if (bus.rsp_ready) begin
        rsp_vld_p1   <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid   = rsp_vld_p1;
  assign bus.rsp_illegal = rsp_ill_p1;
  assign bus.rsp_rdata   = rsp_rdata_p1;
  assign timer_irq       = irq_q;
  assign count_out       = count_q;

endmodule

// File: tb/tb_cp0_regfile_ctrl.sv
// Directed bench for cp0_regfile_ctrl: register access, illegal index,
// backpressure, reset mid-response and Count/Compare timer corner cases.
module tb_cp0_regfile_ctrl;

  localparam logic [255:0] MASK = ~(256'd1 << (7*8 + 2));

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_irq;
  logic [31:0] count_out;

  int n_cmp = 0;
  int n_err = 0;

  logic        cap_valid, cap_ill, cap_irq;
  logic [31:0] cap_rdata, cap_cnt;

  cp0_if #(.DATA_W(32), .SEL_W(3)) bus ();

  cp0_regfile_ctrl #(
    .DATA_W(32), .SEL_W(3), .IMPL_MASK(MASK), .COUNT_DIV(2),
    .STATUS_RST(32'h0040_0004)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .timer_irq(timer_irq), .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic [4:0] rd, input logic [2:0] sel,
                         input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_rd    = rd;
    bus.req_sel   = sel;
    bus.req_wdata = wd;
  endtask

  // One accepted access; outputs captured one cycle after acceptance, then drained.
  task automatic xact(input logic wr, input logic [4:0] rd, input logic [2:0] sel,
                      input logic [31:0] wd);
    set_req(wr, rd, sel, wd);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    cap_valid = bus.rsp_valid;
    cap_rdata = bus.rsp_rdata;
    cap_ill   = bus.rsp_illegal;
    cap_irq   = timer_irq;
    cap_cnt   = count_out;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_rd    = '0;
    bus.req_sel   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_illegal", bus.rsp_illegal, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_count", count_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Status write then read-back
    xact(1'b1, 5'd12, 3'd0, 32'h1234_5678);
    chk("wr_status_valid", cap_valid, 1);
    chk("wr_status_rdata", cap_rdata, 0);
    chk("wr_status_ill", cap_ill, 0);
    xact(1'b0, 5'd12, 3'd0, 32'h0);
    chk("rd_status_valid", cap_valid, 1);
    chk("rd_status_rdata", cap_rdata, 32'h1234_5678);
    chk("rd_status_ill", cap_ill, 0);

    // Reset while a response is held
    set_req(1'b0, 5'd12, 3'd0, 32'h0);
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("held_valid", bus.rsp_valid, 1);
    chk("held_rdata", bus.rsp_rdata, 32'h1234_5678);
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_irq", timer_irq, 0);
    chk("midrst_rdata", bus.rsp_rdata, 0);
    chk("midrst_count", count_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    xact(1'b0, 5'd12, 3'd0, 32'h0);
    chk("status_after_rst", cap_rdata, 32'h0040_0004);

    // Unimplemented index rd7 sel2
    xact(1'b1, 5'd7, 3'd1, 32'hA5A5_0001);
    xact(1'b1, 5'd7, 3'd2, 32'hDEAD_BEEF);
    chk("ill_wr_ill", cap_ill, 1);
    chk("ill_wr_rdata", cap_rdata, 0);
    xact(1'b0, 5'd7, 3'd2, 32'h0);
    chk("ill_rd_ill", cap_ill, 1);
    chk("ill_rd_rdata", cap_rdata, 0);
    xact(1'b0, 5'd7, 3'd1, 32'h0);
    chk("neighbor_rdata", cap_rdata, 32'hA5A5_0001);
    chk("neighbor_ill", cap_ill, 0);

    // Backpressure then back-to-back drain
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 5'd12, 3'd0, 32'h0);
    @(posedge clk); #1;
    chk("bp_first_valid", bus.rsp_valid, 1);
    set_req(1'b0, 5'd7, 3'd1, 32'h0);
    repeat (3) begin
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_rdata_stable", bus.rsp_rdata, 32'h0040_0004);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    chk("b2b_1_valid", bus.rsp_valid, 1);
    chk("b2b_1_rdata", bus.rsp_rdata, 32'hA5A5_0001);
    set_req(1'b0, 5'd12, 3'd0, 32'h0);
    @(posedge clk); #1;
    chk("b2b_2_valid", bus.rsp_valid, 1);
    chk("b2b_2_rdata", bus.rsp_rdata, 32'h0040_0004);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", bus.rsp_valid, 0);

    // Count wrap onto Compare=0
    set_req(1'b1, 5'd9, 3'd0, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("cnt_wr", count_out, 32'hFFFF_FFFE);
    set_req(1'b1, 5'd11, 3'd0, 32'h0);
    @(posedge clk); #1;
    chk("cmp_wr_irq_clr", timer_irq, 0);
    chk("cnt_e1", count_out, 32'hFFFF_FFFE);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("cnt_e2", count_out, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("cnt_e3", count_out, 32'hFFFF_FFFF);
    chk("irq_e3", timer_irq, 0);
    @(posedge clk); #1;
    chk("cnt_wrap", count_out, 32'h0);
    chk("irq_set", timer_irq, 1);
    xact(1'b0, 5'd13, 3'd0, 32'h0);
    chk("cause_ti", cap_rdata, 32'h4000_0000);
    xact(1'b1, 5'd11, 3'd0, 32'h100);
    chk("cmp_clear_irq", cap_irq, 0);
    xact(1'b1, 5'd13, 3'd0, 32'hFFFF_FFFF);
    xact(1'b0, 5'd13, 3'd0, 32'h0);
    chk("cause_bit30_ro", cap_rdata, 32'hBFFF_FFFF);

    // Count write coincident with a prescaler tick
    xact(1'b1, 5'd9, 3'd0, 32'h10);
    xact(1'b1, 5'd9, 3'd0, 32'h50);
    chk("cnt_wr_wins", cap_cnt, 32'h50);
    chk("cnt_presc_rst", count_out, 32'h50);
    @(posedge clk); #1;
    chk("cnt_after_tick", count_out, 32'h51);

    // Compare write on the matching edge
    xact(1'b1, 5'd9, 3'd0, 32'hFF);
    xact(1'b1, 5'd11, 3'd0, 32'h200);
    chk("match_cnt", cap_cnt, 32'h100);
    chk("match_cmp_wins", cap_irq, 0);
    chk("match_irq_after", timer_irq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_regfile_ctrl.md
Name: cp0_regfile_ctrl

Overview:
- Parametrised CP0 register file with a built-in register-number decoder; the successor to the purely combinational rd/sel-to-index mapping.
- Decodes (rd, sel) to a flat index, stores implemented registers, serves mfc0/mtc0 through a valid/ready request and response handshake with a one-entry response buffer, and runs the Count/Compare timer.
- Sits between the pipeline's CP0 access stage and the exception/interrupt logic.

Parameters:
- DATA_W, 32, register width.
- SEL_W, 3, width of sel field; NUM_SEL = 2**SEL_W.
- IMPL_MASK, {32*NUM_SEL{1'b1}}, bit i=1 means flat index i (= rd*NUM_SEL+sel) is implemented.
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (>=1).
- STATUS_RST, 32'h0040_0004, reset value of Status (rd12 sel0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_write  in  1  1 = mtc0, 0 = mfc0.
- req_rd  in  5  CP0 register number.
- req_sel  in  SEL_W  select field.
- req_wdata  in  DATA_W  mtc0 data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  mfc0 data; 0 for writes/illegal.
- rsp_illegal  out  1  index not implemented.
- timer_irq  out  1  Count==Compare pending interrupt.
- count_out  out  DATA_W  live Count value.

Behaviour:
- Reset (async, rst_n low): every stored register 0 except Status=STATUS_RST. rsp_valid=0, rsp_rdata=0, rsp_illegal=0, timer_irq=0, prescaler=0, count_out=0. Reset mid-transaction discards the buffered response.
- Decode: idx = {req_rd, req_sel}. Legal iff IMPL_MASK[idx]. No X outputs for any rd/sel.
- Handshake: req_ready = !rsp_valid || rsp_ready. On acceptance, at the next edge: rsp_valid=1, rsp_illegal=!legal, rsp_rdata = (read && legal) ? value : 0. Read value is sampled at the acceptance edge, before any same-edge Count increment. Read latency is 1 cycle.
- Response buffer: rsp_valid holds with stable data until rsp_ready. Accept-and-drain in the same cycle gives back-to-back throughput of 1/cycle. When drained with no new request, rsp_valid drops to 0.
- Writes take effect at the acceptance edge. Illegal writes are dropped with rsp_illegal=1.
- Cause (rd13 sel0) read: bit 30 reflects timer_irq. Stored bit 30 is not software-writable.
- Prescaler counts 0..COUNT_DIV-1. Count (rd9 sel0) increments by 1 mod 2**DATA_W, wrapping from all-ones to 0, when the prescaler hits COUNT_DIV-1.
- A software write to Count wins over a same-edge increment and resets the prescaler to 0.
- Compare (rd11 sel0) write clears timer_irq and stores the new value.
- timer_irq sets on the edge where next-Count equals Compare and no Compare write is accepted that edge. Compare write wins over a simultaneous match. Once set, timer_irq stays set until a Compare write or reset.
- count_out = Count register, registered.

Test Plan:
- Reset: assert rst_n=0 mid-response → rsp_valid=0, timer_irq=0, Status read after release = 32'h0040_0004.
- mtc0 rd=12 sel=0 data 32'h1234_5678, then mfc0 same → second response rsp_rdata=32'h1234_5678, rsp_illegal=0, each 1 cycle after acceptance.
- IMPL_MASK with bit for rd=7 sel=2 cleared: mfc0 and mtc0 to it → rsp_illegal=1, rsp_rdata=0, storage unchanged.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_rdata stable. Then rsp_ready=1 → new request accepted in the same cycle, responses 1/cycle.
- Timer (COUNT_DIV=2): write Count=32'hFFFF_FFFE, Compare=0 → Count wraps to 0 after 4 clocks, timer_irq=1, Cause bit30=1. Write Compare → timer_irq=0 next edge.
- Simultaneous events: Count write coincident with increment → written value wins. Compare write on the match edge → timer_irq stays 0.
